// File: rtl/sample_reg_arbiter.sv
// sample_reg_arbiter: round-robin arbiter feeding one shared sample holding
// register, presented downstream with a valid/ready handshake.
// A drain and a new load may happen in the same cycle, giving one sample per
// cycle when the consumer keeps out_ready high.
module sample_reg_arbiter #(
    parameter int WIDTH = 24,
    parameter int N_REQ = 4
) (
    input  logic                       clk,
    input  logic                       reset,      // active-low, asynchronous
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(N_REQ)-1:0]   out_src,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int SRC_W = $clog2(N_REQ);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;       // index of the last accepted requester
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SRC_W-1:0]   src_q, src_d;

    logic               found;
    logic [SRC_W-1:0]   winner;
    logic [SRC_W-1:0]   cand;
    int                 cand_int;
    logic               slot_free;
    logic               accept;

    // Round-robin search starting just after ptr, wrapping, ending at ptr itself.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        cand     = '0;
        cand_int = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_int = (int'(ptr_q) + k) % N_REQ;
            cand     = cand_int[SRC_W-1:0];
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // The register can take a new sample when empty or when being drained now.
    // Grants are suppressed while reset is held so nothing is offered to producers.
    always_comb begin
        slot_free = (state_q == EMPTY) || out_ready;
        accept    = found && slot_free && reset;
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
            assign req_ready[gi] = accept && (winner == SRC_W'(gi));
        end
    endgenerate

    // Next-state logic: load on accept, otherwise fall back to EMPTY on a drain.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        src_d   = src_q;
        if (accept) begin
            state_d = FULL;
            ptr_d   = winner;
            src_d   = winner;
            data_d  = req_data[winner*WIDTH +: WIDTH];
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
        end
    end

    // State register; reset discards any held sample and gives requester 0 priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            ptr_q   <= SRC_W'(N_REQ - 1);
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;

endmodule

// File: tb/tb_sample_reg_arbiter.sv
// Self-checking bench for sample_reg_arbiter: directed scenarios followed by a
// randomized phase, all checked against a transaction-level model.
module tb_sample_reg_arbiter;

    localparam int WIDTH = 24;
    localparam int N_REQ = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]       out_data;
    logic [1:0]             out_src;
    logic                   out_valid;
    logic                   out_ready;

    int n_checks = 0;
    int n_fails  = 0;

    // Model: holding register contents plus the round-robin pointer.
    bit          m_full;
    logic [23:0] m_data;
    int          m_src;
    int          m_ptr;

    sample_reg_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_grant();
        if (m_full && !out_ready) return 4'b0000;
        for (int k = 1; k <= N_REQ; k++) begin
            int i;
            i = (m_ptr + k) % N_REQ;
            if (req_valid[i]) return 4'(1 << i);
        end
        return 4'b0000;
    endfunction

    function automatic logic [23:0] slot(input int i);
        logic [N_REQ*WIDTH-1:0] v;
        v = req_data;
        return v[i*WIDTH +: WIDTH];
    endfunction

    task automatic model_reset();
        m_full = 1'b0;
        m_data = '0;
        m_src  = 0;
        m_ptr  = N_REQ - 1;
    endtask

    // One clock cycle: check the combinational grant mid-cycle, advance the
    // model, then check the registered outputs just after the edge.
    task automatic step(input string tag);
        logic [3:0] g;
        @(negedge clk);
        g = model_grant();
        check({tag, ".req_ready"}, 64'(req_ready), 64'(g));
        if (g != 4'b0000) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (g[i]) begin
                    m_data = slot(i);
                    m_src  = i;
                    m_ptr  = i;
                end
            end
            m_full = 1'b1;
        end else if (m_full && out_ready) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
        check({tag, ".out_valid"}, 64'(out_valid), 64'(m_full));
        check({tag, ".out_data"},  64'(out_data),  64'(m_data));
        check({tag, ".out_src"},   64'(out_src),   64'(m_src));
    endtask

    task automatic set_data(input logic [23:0] d0, input logic [23:0] d1,
                            input logic [23:0] d2, input logic [23:0] d3);
        req_data = {d3, d2, d1, d0};
    endtask

    initial begin
        // ---- reset at time zero, with requests pending ----
        reset     = 1'b0;
        req_valid = 4'b1111;
        out_ready = 1'b0;
        set_data(24'd8, 24'd9, 24'd10, 24'd11);
        model_reset();
        #3;
        check("rst0.out_valid", 64'(out_valid), 64'(0));
        check("rst0.out_data",  64'(out_data),  64'(0));
        check("rst0.out_src",   64'(out_src),   64'(0));
        check("rst0.req_ready", 64'(req_ready), 64'(0));
        #9 reset = 1'b1;                    // release away from any edge
        #1;
        check("rst_rel.req_ready", 64'(req_ready), 64'(4'b0001));
        @(posedge clk); #1;                 // first sampling edge is the one above? resync
        model_reset();
        check("rst_rel.idle_valid", 64'(out_valid), 64'(1));
        // The edge above accepted requester 0 (req_ready was high), mirror it.
        m_full = 1'b1; m_data = 24'd8; m_src = 0; m_ptr = 0;
        check("rst_rel.src", 64'(out_src), 64'(0));

        // ---- round-robin rotation, continuous drain ----
        out_ready = 1'b1;
        for (int c = 1; c < 8; c++) begin
            step($sformatf("rot%0d", c));
            check($sformatf("rot%0d.src_const", c), 64'(out_src), 64'(c % 4));
            check($sformatf("rot%0d.data_const", c), 64'(out_data), 64'(8 + (c % 4)));
        end

        // ---- drain to empty ----
        req_valid = 4'b0000;
        step("drain");
        check("drain.valid_const", 64'(out_valid), 64'(0));

        // ---- single requester with backpressure ----
        req_valid = 4'b0100;
        out_ready = 1'b0;
        set_data(24'h0, 24'h0, 24'h000064, 24'h0);
        step("single");
        check("single.data_const", 64'(out_data), 64'(24'h000064));
        check("single.src_const",  64'(out_src),  64'(2));
        req_valid = 4'b0000;
        step("single_hold");
        out_ready = 1'b1;
        step("single_drain");
        check("single_drain.valid_const", 64'(out_valid), 64'(0));

        // ---- backpressure while FULL ----
        req_valid = 4'b0001;
        out_ready = 1'b0;
        set_data(24'hABCDEF, 24'd1, 24'd2, 24'd3);
        step("bp_load");
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            step($sformatf("bp%0d", c));
            check($sformatf("bp%0d.data_const", c), 64'(out_data), 64'(24'hABCDEF));
        end
        out_ready = 1'b1;
        #1;
        check("bp_next.grant_const", 64'(req_ready), 64'(4'b0010));
        step("bp_next");

        // ---- simultaneous drain and load, then wrap/skip ----
        req_valid = 4'b1000;
        #1;
        check("dl.grant_const", 64'(req_ready), 64'(4'b1000));
        step("dl");
        check("dl.src_const", 64'(out_src), 64'(3));
        req_valid = 4'b0000;
        step("dl_drain");
        req_valid = 4'b0010;
        step("wrap1");
        check("wrap1.src_const", 64'(out_src), 64'(1));
        req_valid = 4'b0011;
        #1;
        check("wrap0.grant_const", 64'(req_ready), 64'(4'b0001));
        step("wrap0");

        // ---- randomized traffic ----
        for (int c = 0; c < 300; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            set_data(24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
            step($sformatf("rnd%0d", c));
        end

        // ---- asynchronous reset mid-operation ----
        req_valid = 4'b0100;
        out_ready = 1'b0;
        step("pre_rst");
        check("pre_rst.valid_const", 64'(out_valid), 64'(1));
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("rst1.out_valid", 64'(out_valid), 64'(0));
        check("rst1.out_data",  64'(out_data),  64'(0));
        check("rst1.out_src",   64'(out_src),   64'(0));
        check("rst1.req_ready", 64'(req_ready), 64'(0));
        @(posedge clk); #1;
        check("rst1.held_valid", 64'(out_valid), 64'(0));
        reset = 1'b1;
        req_valid = 4'b1010;
        out_ready = 1'b1;
        step("post_rst");
        check("post_rst.src_const", 64'(out_src), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/sample_reg_arbiter.md
# sample_reg_arbiter

Round-robin arbiter that shares a single 24-bit sample holding register between N_REQ audio-sample producers, such as the codec input path, the filter stage and the echo/noise generators. The block grants one requester per cycle and captures its sample into the holding register. It presents that sample with a valid/ready handshake to a single downstream consumer, such as the codec output path. Throughput is one sample per cycle when the consumer drains continuously.

## Interface
Parameters:
- WIDTH, 24, sample width in bits
- N_REQ, 4, number of requesters (≥2)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- req_valid  input  N_REQ  bit i set: requester i offers a sample
- req_data  input  N_REQ*WIDTH  requester i sample on bits [i*WIDTH +: WIDTH]
- req_ready  output  N_REQ  one-hot (or zero) grant; combinational
- out_data  output  WIDTH  held sample
- out_src  output  $clog2(N_REQ)  index of requester that supplied out_data
- out_valid  output  1  holding register contains an unconsumed sample
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- State machine with two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- slot_free = EMPTY, or (FULL and out_ready).
- Grant selection:
  - Let ptr be the index of the last accepted requester.
  - Search indices ptr+1, ptr+2, … wrapping modulo N_REQ, ending at ptr itself.
  - The first i with req_valid[i]=1 is the winner.
  - req_ready[winner]=1 only if slot_free. All other bits are 0.
  - If no req_valid is set, or the slot is not free, req_ready=0.
- Accept: the transfer occurs when req_valid[i] and req_ready[i] in the same cycle. On the next edge:
  - out_data ← req_data[i]
  - out_src ← i
  - ptr ← i
  - state → FULL
- Drain: occurs when FULL and out_ready.
  - With no accept in the same cycle: state → EMPTY. out_data and out_src keep their last values.
  - With an accept in the same cycle: state stays FULL and the new sample loads. This is back-to-back operation with no bubble.
- FULL and not out_ready: out_data, out_src and ptr hold. req_ready=0.
- ptr changes only on accept. Drains and idle cycles never move ptr.
- Requester i may drop req_valid before being granted; no penalty applies and ptr does not change.
- out_ready while EMPTY is ignored.

## Timing
- Reset values, applied immediately on reset=0 regardless of clk:
  - state = EMPTY, out_valid=0
  - out_data=0, out_src=0
  - ptr = N_REQ-1, so requester 0 has first priority after reset
- req_ready depends combinationally on req_valid, out_ready, state and ptr. It has no dependency on req_data.
- Latency: a sample accepted at edge k is visible on out_data with out_valid=1 immediately after edge k. That is one cycle from request to output.
- Sustained rate: 1 sample/cycle while out_ready=1 and any req_valid=1.
- Fairness: with all requesters continuously valid and out_ready=1, grants rotate 0,1,…,N_REQ-1,0,… Each requester waits at most N_REQ-1 grants.
- Reset asserted mid-operation:
  - A held sample is discarded (out_valid→0).
  - ptr returns to N_REQ-1.
  - req_ready=0 while reset=0.
- Reset deassertion is synchronised externally. The block samples inputs from the first edge after release.

## Test plan
- Reset: reset=0 with out_valid previously 1 -> out_valid=0, out_data=0, out_src=0 asynchronously, before the next clk edge. After release, req_valid=4'b1111 -> req_ready=4'b0001.
- Single requester: req_valid=4'b0100 with sample 24'h00_0064, out_ready=0 -> accept. Next cycle: out_valid=1, out_data=24'h000064, out_src=2, req_ready=0 while held. Then out_ready=1 for one cycle -> EMPTY.
- Round-robin rotation: all valid, data[i]=24'd8+i, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3 with out_data tracking each source. out_valid stays 1 throughout with no bubbles.
- Backpressure: FULL holding 24'hABCDEF, out_ready=0 for 5 cycles with all req_valid=1 -> out_data stable, req_ready=0 every cycle, ptr unchanged. The next grant is ptr+1.
- Wrap/skip: ptr=3, req_valid=4'b0010 -> requester 1 granted. Then req_valid=4'b0011 -> requester 0 granted next, because the search wraps from 2 through 3 to 0.
- Simultaneous drain and load: FULL, out_ready=1, req_valid=4'b1000 -> same-cycle req_ready=4'b1000. Next cycle: out_valid=1 and out_src=3 with the new data.
